// File: rtl/registro_tiempo_vga_banco_pkg.sv
// Shared definitions for the VGA time/date register bank: FSM states,
// field indices and the default per-field BCD limits.
package registro_tiempo_vga_banco_pkg;

  localparam int NCH_DEF    = 6;
  localparam int W_DEF      = 8;
  localparam int ADDR_W_DEF = 3;

  localparam int CH_SEG = 0;
  localparam int CH_MIN = 1;
  localparam int CH_HOR = 2;
  localparam int CH_DIA = 3;
  localparam int CH_MES = 4;
  localparam int CH_ANO = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PENDING
  } estado_t;

  // Packs six per-field limits into the flattened field-i-at-[i*W +: W] layout
  function automatic logic [NCH_DEF*W_DEF-1:0] lim_vec(
    input logic [W_DEF-1:0] seg,
    input logic [W_DEF-1:0] mnt,
    input logic [W_DEF-1:0] hor,
    input logic [W_DEF-1:0] dia,
    input logic [W_DEF-1:0] mes,
    input logic [W_DEF-1:0] ano
  );
    logic [NCH_DEF*W_DEF-1:0] v;
    v = '0;
    v[CH_SEG*W_DEF +: W_DEF] = seg;
    v[CH_MIN*W_DEF +: W_DEF] = mnt;
    v[CH_HOR*W_DEF +: W_DEF] = hor;
    v[CH_DIA*W_DEF +: W_DEF] = dia;
    v[CH_MES*W_DEF +: W_DEF] = mes;
    v[CH_ANO*W_DEF +: W_DEF] = ano;
    return v;
  endfunction

  localparam logic [NCH_DEF*W_DEF-1:0] MAX_VEC_DEF =
    lim_vec(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99);
  localparam logic [NCH_DEF*W_DEF-1:0] MIN_VEC_DEF =
    lim_vec(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);

endpackage

// File: rtl/registro_tiempo_vga_banco_bcd_paso.sv
// Combinational BCD step (+1/-1) with MIN/MAX wrap, plus a flag telling
// whether an incoming write value is valid BCD and inside [min_v, max_v].
module bcd_paso #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic [W-1:0] dseg,
  input  logic [W-1:0] min_v,
  input  logic [W-1:0] max_v,
  input  logic         up,
  output logic [W-1:0] paso,
  output logic         ok
);

  localparam int ND = W / 4;

  logic c;

  // Digit-wise ripple step; valid BCD compares correctly as plain binary
  always_comb begin
    paso = val;
    c    = 1'b1;
    ok   = (dseg >= min_v) && (dseg <= max_v);
    for (int unsigned d = 0; d < ND; d++) begin
      if (dseg[d*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (up) begin
      if ((val < min_v) || (val >= max_v)) begin
        paso = min_v;
      end else begin
        for (int unsigned d = 0; d < ND; d++) begin
          if (c) begin
            if (paso[d*4 +: 4] == 4'd9) begin
              paso[d*4 +: 4] = 4'd0;
            end else begin
              paso[d*4 +: 4] = paso[d*4 +: 4] + 4'd1;
              c = 1'b0;
            end
          end
        end
      end
    end else begin
      if (val <= min_v) begin
        paso = max_v;
      end else begin
        for (int unsigned d = 0; d < ND; d++) begin
          if (c) begin
            if (paso[d*4 +: 4] == 4'd0) begin
              paso[d*4 +: 4] = 4'd9;
            end else begin
              paso[d*4 +: 4] = paso[d*4 +: 4] - 4'd1;
              c = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/registro_tiempo_vga_banco.sv
// Addressed bank of BCD time/date fields for the VGA text renderer.
// Writes (RTC burst or user edit) land in a shadow bank that is copied to
// the display bank only on a frame boundary.
import registro_tiempo_vga_banco_pkg::*;

module registro_tiempo_vga_banco #(
  parameter int                    NCH     = NCH_DEF,
  parameter int                    W       = W_DEF,
  parameter int                    ADDR_W  = ADDR_W_DEF,
  parameter logic [NCH*W-1:0]      MAX_VEC = MAX_VEC_DEF,
  parameter logic [NCH*W-1:0]      MIN_VEC = MIN_VEC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seleccion,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      dseg,
  input  logic              EN,
  input  logic              ACT,
  input  logic              inc,
  input  logic              dec,
  input  logic              burst_done,
  input  logic              vsync_pulse,
  output logic [NCH*W-1:0]  dato_flat,
  output logic              dirty,
  output logic              commit_pulse,
  output logic              err
);

  estado_t     st, st_sig;
  logic [W-1:0] sh   [NCH];
  logic [W-1:0] disp [NCH];
  logic         sel_q;
  logic         addr_ok, wr, stp, req, rechazo, acepta, commit_now, dseg_ok;
  logic [W-1:0] cur, mn, mx, paso_v, nuevo;

  // Select the addressed shadow field and its limits
  always_comb begin
    cur = '0;
    mn  = '0;
    mx  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(addr) == i) begin
        cur = sh[i];
        mn  = MIN_VEC[i*W +: W];
        mx  = MAX_VEC[i*W +: W];
      end
    end
  end

  bcd_paso #(.W(W)) u_paso (
    .val   (cur),
    .dseg  (dseg),
    .min_v (mn),
    .max_v (mx),
    .up    (inc),
    .paso  (paso_v),
    .ok    (dseg_ok)
  );

  // Decode the request for this cycle; ACT beats inc/dec, inc&dec is a no-op
  always_comb begin
    addr_ok = 32'(addr) < 32'(NCH);
    wr      = seleccion ? ACT : EN;
    stp     = seleccion && !ACT && (inc ^ dec);
    req     = wr || stp;
    rechazo = req && (!addr_ok || (wr && !dseg_ok));
    acepta  = req && !rechazo;
    nuevo   = wr ? dseg : paso_v;
  end

  // State register and mode tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= ST_IDLE;
      sel_q <= 1'b0;
    end else begin
      st    <= st_sig;
      sel_q <= seleccion;
    end
  end

  // Next state; a mode change folds any outstanding work into PENDING
  always_comb begin
    st_sig = st;
    case (st)
      ST_IDLE:    if (acepta) st_sig = seleccion ? ST_PENDING : ST_COLLECT;
      ST_COLLECT: if (burst_done) st_sig = ST_PENDING;
      ST_PENDING: begin
        if (vsync_pulse) begin
          if (acepta) st_sig = seleccion ? ST_PENDING : ST_COLLECT;
          else        st_sig = ST_IDLE;
        end
      end
      default:    st_sig = ST_IDLE;
    endcase
    if (seleccion != sel_q) st_sig = (st_sig != ST_IDLE) ? ST_PENDING : ST_IDLE;
  end

  // FSM outputs
  always_comb begin
    dirty      = (st != ST_IDLE);
    commit_now = (st == ST_PENDING) && vsync_pulse;
  end

  // Shadow bank: at most one field updated per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) sh[i] <= '0;
    end else if (acepta) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (32'(addr) == i) sh[i] <= nuevo;
      end
    end
  end

  // Display bank: whole-frame copy of the pre-edge shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) disp[i] <= '0;
    end else if (commit_now) begin
      for (int unsigned i = 0; i < NCH; i++) disp[i] <= sh[i];
    end
  end

  // Registered one-cycle status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_pulse <= 1'b0;
      err          <= 1'b0;
    end else begin
      commit_pulse <= commit_now;
      err          <= rechazo;
    end
  end

  // Flatten the display bank for the renderer
  always_comb begin
    dato_flat = '0;
    for (int unsigned i = 0; i < NCH; i++) dato_flat[i*W +: W] = disp[i];
  end

endmodule

// File: tb/tb_registro_tiempo_vga_banco.sv
// Self-checking bench: directed scenarios then randomized traffic, all
// compared against a decimal-valued behavioural model of the bank.
module tb_registro_tiempo_vga_banco;

  localparam int NCH = 6;
  localparam int W   = 8;
  localparam int AW  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic seleccion = 1'b0, EN = 1'b0, ACT = 1'b0, inc = 1'b0, dec = 1'b0;
  logic burst_done = 1'b0, vsync_pulse = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  dseg = '0;
  logic [NCH*W-1:0] dato_flat;
  logic dirty, commit_pulse, err;

  always #5 clk = ~clk;

  registro_tiempo_vga_banco dut (
    .clk          (clk),
    .reset        (reset),
    .seleccion    (seleccion),
    .addr         (addr),
    .dseg         (dseg),
    .EN           (EN),
    .ACT          (ACT),
    .inc          (inc),
    .dec          (dec),
    .burst_done   (burst_done),
    .vsync_pulse  (vsync_pulse),
    .dato_flat    (dato_flat),
    .dirty        (dirty),
    .commit_pulse (commit_pulse),
    .err          (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic revisar(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal values) ----------------
  int lim_max [NCH] = '{59, 59, 23, 31, 12, 99};
  int lim_min [NCH] = '{0, 0, 0, 1, 1, 0};
  int m_sh   [NCH];
  int m_disp [NCH];
  bit m_collecting, m_awaiting, m_commit, m_err, m_selq;

  function automatic int de_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] a_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic modelo_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = 0;
      m_disp[i] = 0;
    end
    m_collecting = 0; m_awaiting = 0; m_commit = 0; m_err = 0; m_selq = 0;
  endtask

  task automatic modelo_flanco();
    bit sel_chg, wr, stp, req, acc, rej, ok_dato, had;
    int a, nv, v;
    a       = int'(addr);
    sel_chg = (seleccion != m_selq);
    wr      = seleccion ? ACT : EN;
    stp     = seleccion && !ACT && (inc != dec);
    req     = wr || stp;
    ok_dato = 0;
    if (a < NCH && dseg[7:4] <= 9 && dseg[3:0] <= 9)
      ok_dato = (de_bcd(dseg) >= lim_min[a]) && (de_bcd(dseg) <= lim_max[a]);
    rej = req && (a >= NCH || (wr && !ok_dato));
    acc = req && !rej;
    nv  = 0;
    if (acc) begin
      if (wr) nv = de_bcd(dseg);
      else begin
        v = m_sh[a];
        if (inc) nv = (v < lim_min[a] || v >= lim_max[a]) ? lim_min[a] : v + 1;
        else     nv = (v <= lim_min[a]) ? lim_max[a] : v - 1;
      end
    end
    m_commit = m_awaiting && vsync_pulse;
    if (m_commit) for (int i = 0; i < NCH; i++) m_disp[i] = m_sh[i];
    if (acc) m_sh[a] = nv;
    m_err = rej;
    if (m_awaiting && vsync_pulse) begin
      m_awaiting = 0;
      if (acc) begin
        if (seleccion) m_awaiting = 1; else m_collecting = 1;
      end
    end else if (m_collecting) begin
      if (burst_done) begin m_collecting = 0; m_awaiting = 1; end
    end else if (!m_awaiting && acc) begin
      if (seleccion) m_awaiting = 1; else m_collecting = 1;
    end
    if (sel_chg) begin
      had = m_collecting || m_awaiting;
      m_collecting = 0;
      m_awaiting = had;
    end
    m_selq = seleccion;
  endtask

  task automatic comparar();
    logic [NCH*W-1:0] e;
    e = '0;
    for (int i = 0; i < NCH; i++) e[i*W +: W] = a_bcd(m_disp[i]);
    revisar("dato_flat", 64'(dato_flat), 64'(e));
    revisar("dirty", 64'(dirty), 64'(m_collecting || m_awaiting));
    revisar("commit_pulse", 64'(commit_pulse), 64'(m_commit));
    revisar("err", 64'(err), 64'(m_err));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic ciclo();
    @(posedge clk);
    modelo_flanco();
    #1;
    comparar();
  endtask

  task automatic soltar();
    EN = 0; ACT = 0; inc = 0; dec = 0; burst_done = 0; vsync_pulse = 0;
  endtask

  task automatic act_w(input int a, input logic [7:0] d);
    addr = AW'(a); dseg = d; ACT = 1; ciclo(); ACT = 0;
  endtask

  task automatic en_w(input int a, input logic [7:0] d);
    addr = AW'(a); dseg = d; EN = 1; ciclo(); EN = 0;
  endtask

  task automatic paso_u(input int a, input bit up);
    addr = AW'(a); inc = up; dec = !up; ciclo(); inc = 0; dec = 0;
  endtask

  task automatic frame();
    vsync_pulse = 1; ciclo(); vsync_pulse = 0;
  endtask

  task automatic aplicar_reset();
    soltar();
    reset = 1;
    #2;
    modelo_reset();
    comparar();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    modelo_reset();
    #1;
    aplicar_reset();
    revisar("rst_dato", 64'(dato_flat), 64'd0);
    revisar("rst_dirty", 64'(dirty), 64'd0);

    // 1: RTC burst, hidden until the frame boundary
    seleccion = 0; ciclo();
    en_w(4, 8'h12);
    revisar("t1_mes_oculto", 64'(dato_flat[39:32]), 64'h00);
    revisar("t1_dirty", 64'(dirty), 64'd1);
    burst_done = 1; ciclo(); burst_done = 0;
    repeat (3) ciclo();
    revisar("t1_mes_espera", 64'(dato_flat[39:32]), 64'h00);
    frame();
    revisar("t1_mes_commit", 64'(dato_flat[39:32]), 64'h12);
    revisar("t1_commit", 64'(commit_pulse), 64'd1);
    ciclo();
    revisar("t1_commit_fin", 64'(commit_pulse), 64'd0);
    revisar("t1_dirty_fin", 64'(dirty), 64'd0);

    // 2: user steps with wrap
    seleccion = 1; ciclo();
    act_w(4, 8'h12); paso_u(4, 1); frame();
    revisar("t2_mes_inc_wrap", 64'(dato_flat[39:32]), 64'h01);
    paso_u(4, 0); frame();
    revisar("t2_mes_dec_wrap", 64'(dato_flat[39:32]), 64'h12);
    act_w(0, 8'h09); paso_u(0, 1); frame();
    revisar("t2_seg_carry", 64'(dato_flat[7:0]), 64'h10);
    act_w(0, 8'h59); paso_u(0, 1); frame();
    revisar("t2_seg_wrap", 64'(dato_flat[7:0]), 64'h00);

    // 3: rejected writes
    act_w(4, 8'h1A);
    revisar("t3_err_nibble", 64'(err), 64'd1);
    ciclo();
    revisar("t3_err_fin", 64'(err), 64'd0);
    act_w(6, 8'h05);
    revisar("t3_err_addr", 64'(err), 64'd1);
    act_w(4, 8'h13);
    revisar("t3_err_rango", 64'(err), 64'd1);
    frame();
    revisar("t3_sin_commit", 64'(commit_pulse), 64'd0);
    revisar("t3_mes_igual", 64'(dato_flat[39:32]), 64'h12);

    // 4: write on the commit edge stays pending for the next frame
    act_w(4, 8'h05);
    addr = 3'd4; dseg = 8'h06; ACT = 1; vsync_pulse = 1; ciclo(); soltar();
    revisar("t4_mes_05", 64'(dato_flat[39:32]), 64'h05);
    revisar("t4_dirty", 64'(dirty), 64'd1);
    frame();
    revisar("t4_mes_06", 64'(dato_flat[39:32]), 64'h06);

    // 5: inc&dec together and EN in user mode are no-ops
    addr = 3'd4; inc = 1; dec = 1; ciclo(); soltar();
    revisar("t5_incdec_err", 64'(err), 64'd0);
    revisar("t5_incdec_dirty", 64'(dirty), 64'd0);
    en_w(4, 8'h07);
    revisar("t5_en_ignorado", 64'(dirty), 64'd0);
    frame();
    revisar("t5_mes_igual", 64'(dato_flat[39:32]), 64'h06);

    // 6: reset in the middle of a burst
    seleccion = 0; ciclo();
    en_w(0, 8'h11); en_w(1, 8'h22); en_w(2, 8'h13);
    revisar("t6_dirty_pre", 64'(dirty), 64'd1);
    aplicar_reset();
    revisar("t6_dato_cero", 64'(dato_flat), 64'd0);
    revisar("t6_dirty_cero", 64'(dirty), 64'd0);
    frame();
    revisar("t6_sin_commit", 64'(commit_pulse), 64'd0);
    revisar("t6_dato_post", 64'(dato_flat), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        aplicar_reset();
      end else begin
        if ($urandom_range(0, 39) == 0) seleccion = !seleccion;
        addr = AW'($urandom_range(0, 7));
        if ($urandom_range(0, 9) < 7) dseg = a_bcd($urandom_range(0, 99));
        else dseg = 8'($urandom);
        EN          = ($urandom_range(0, 9) < 3);
        ACT         = ($urandom_range(0, 9) < 2);
        inc         = ($urandom_range(0, 9) < 3);
        dec         = ($urandom_range(0, 9) < 3);
        burst_done  = ($urandom_range(0, 9) < 1);
        vsync_pulse = ($urandom_range(0, 7) == 0);
        ciclo();
      end
    end
    soltar();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
